// File: rtl/sha256_sched_ctrl.sv
// SHA-256 message-schedule and round controller: sequences one 512-bit block through 64 rounds,
// streaming W_t/K_t to the compression core. Optional block counter enabled by SHA256_BLOCK_CNT_EN.
module sha256_sched_ctrl (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         next,
  input  logic [511:0] block_i,
  output logic         init,
  output logic         ready,
  output logic         digest_update,
  output logic         done,
  output logic [31:0]  W_o,
  output logic [31:0]  K_o,
`ifdef SHA256_BLOCK_CNT_EN
  output logic [15:0]  block_cnt,
`endif
  output logic         busy
);

  localparam int DATA_W = 32;
  localparam int STAGES = 64;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    ROUND  = 3'd2,
    UPDATE = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [5:0]          rnd_q;
  logic [DATA_W-1:0]   w_q [16];
  logic [DATA_W-1:0]   w_new;
  logic                accept;

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
    rotr = (x >> n) | (x << (DATA_W - n));
  endfunction

  function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
    sig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
    sig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [DATA_W-1:0] k_rom(input logic [5:0] idx);
    case (idx)
      6'd0:  k_rom = 32'h428a2f98;
      6'd1:  k_rom = 32'h71374491;
      6'd2:  k_rom = 32'hb5c0fbcf;
      6'd3:  k_rom = 32'he9b5dba5;
      6'd4:  k_rom = 32'h3956c25b;
      6'd5:  k_rom = 32'h59f111f1;
      6'd6:  k_rom = 32'h923f82a4;
      6'd7:  k_rom = 32'hab1c5ed5;
      6'd8:  k_rom = 32'hd807aa98;
      6'd9:  k_rom = 32'h12835b01;
      6'd10: k_rom = 32'h243185be;
      6'd11: k_rom = 32'h550c7dc3;
      6'd12: k_rom = 32'h72be5d74;
      6'd13: k_rom = 32'h80deb1fe;
      6'd14: k_rom = 32'h9bdc06a7;
      6'd15: k_rom = 32'hc19bf174;
      6'd16: k_rom = 32'he49b69c1;
      6'd17: k_rom = 32'hefbe4786;
      6'd18: k_rom = 32'h0fc19dc6;
      6'd19: k_rom = 32'h240ca1cc;
      6'd20: k_rom = 32'h2de92c6f;
      6'd21: k_rom = 32'h4a7484aa;
      6'd22: k_rom = 32'h5cb0a9dc;
      6'd23: k_rom = 32'h76f988da;
      6'd24: k_rom = 32'h983e5152;
      6'd25: k_rom = 32'ha831c66d;
      6'd26: k_rom = 32'hb00327c8;
      6'd27: k_rom = 32'hbf597fc7;
      6'd28: k_rom = 32'hc6e00bf3;
      6'd29: k_rom = 32'hd5a79147;
      6'd30: k_rom = 32'h06ca6351;
      6'd31: k_rom = 32'h14292967;
      6'd32: k_rom = 32'h27b70a85;
      6'd33: k_rom = 32'h2e1b2138;
      6'd34: k_rom = 32'h4d2c6dfc;
      6'd35: k_rom = 32'h53380d13;
      6'd36: k_rom = 32'h650a7354;
      6'd37: k_rom = 32'h766a0abb;
      6'd38: k_rom = 32'h81c2c92e;
      6'd39: k_rom = 32'h92722c85;
      6'd40: k_rom = 32'ha2bfe8a1;
      6'd41: k_rom = 32'ha81a664b;
      6'd42: k_rom = 32'hc24b8b70;
      6'd43: k_rom = 32'hc76c51a3;
      6'd44: k_rom = 32'hd192e819;
      6'd45: k_rom = 32'hd6990624;
      6'd46: k_rom = 32'hf40e3585;
      6'd47: k_rom = 32'h106aa070;
      6'd48: k_rom = 32'h19a4c116;
      6'd49: k_rom = 32'h1e376c08;
      6'd50: k_rom = 32'h2748774c;
      6'd51: k_rom = 32'h34b0bcb5;
      6'd52: k_rom = 32'h391c0cb3;
      6'd53: k_rom = 32'h4ed8aa4a;
      6'd54: k_rom = 32'h5b9cca4f;
      6'd55: k_rom = 32'h682e6ff3;
      6'd56: k_rom = 32'h748f82ee;
      6'd57: k_rom = 32'h78a5636f;
      6'd58: k_rom = 32'h84c87814;
      6'd59: k_rom = 32'h8cc70208;
      6'd60: k_rom = 32'h90befffa;
      6'd61: k_rom = 32'ha4506ceb;
      6'd62: k_rom = 32'hbef9a3f7;
      6'd63: k_rom = 32'hc67178f2;
      default: k_rom = '0;
    endcase
  endfunction

  // Requests are honoured only when idle-ish: start in IDLE, start or next in DONE.
  assign accept = ((state_q == IDLE) && start) ||
                  ((state_q == DONE) && (start || next));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = INIT;
      INIT:    state_d = ROUND;
      ROUND:   if (rnd_q == 6'(STAGES - 1)) state_d = UPDATE;
      UPDATE:  state_d = DONE;
      DONE: begin
        if (start)     state_d = INIT;
        else if (next) state_d = ROUND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next schedule word W[t+16] from the sliding window holding W[t..t+15].
  assign w_new = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rnd_q <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else if (accept) begin
      rnd_q <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= block_i[511 - 32*i -: 32];
    end else if (state_q == ROUND) begin
      rnd_q <= rnd_q + 6'd1;
      for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
      w_q[15] <= w_new;
    end
  end

`ifdef SHA256_BLOCK_CNT_EN
  logic [15:0] block_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      block_cnt_q <= '0;
    end else if (state_q == UPDATE) begin
      block_cnt_q <= block_cnt_q + 16'd1;
    end
  end

  assign block_cnt = block_cnt_q;
`endif

  assign init          = (state_q == INIT);
  assign ready         = (state_q == ROUND);
  assign digest_update = (state_q == UPDATE);
  assign done          = (state_q == DONE);
  assign busy          = (state_q == INIT) || (state_q == ROUND) || (state_q == UPDATE);
  assign W_o           = ready ? w_q[0] : '0;
  assign K_o           = ready ? k_rom(rnd_q) : '0;

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// Directed bench for sha256_sched_ctrl: "abc" block, two-block message, request filtering,
// reset mid-round and (with SHA256_BLOCK_CNT_EN) the block counter.
module tb_sha256_sched_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         next;
  logic [511:0] block_i;
  logic         init;
  logic         ready;
  logic         digest_update;
  logic         done;
  logic [31:0]  W_o;
  logic [31:0]  K_o;
  logic         busy;
`ifdef SHA256_BLOCK_CNT_EN
  logic [15:0]  block_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [511:0] blk_abc;
  logic [511:0] blk_m1;
  logic [511:0] blk_m2;
  logic [511:0] blk_junk;

  sha256_sched_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .next          (next),
    .block_i       (block_i),
    .init          (init),
    .ready         (ready),
    .digest_update (digest_update),
    .done          (done),
    .W_o           (W_o),
    .K_o           (K_o),
`ifdef SHA256_BLOCK_CNT_EN
    .block_cnt     (block_cnt),
`endif
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    blk_abc = '0;
    blk_abc[511:480] = 32'h61626380;
    blk_abc[31:0]    = 32'h00000018;
    blk_m1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    blk_m2 = '0;
    blk_m2[31:0] = 32'h000001c0;
    blk_junk = {16{32'hdeadbeef}};

    reset_n = 1'b0; start = 1'b0; next = 1'b0; block_i = '0;
    repeat (3) tick();
    chk("rst_init",  32'(init), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_dupd",  32'(digest_update), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_W",     W_o, 0);
    chk("rst_K",     K_o, 0);
`ifdef SHA256_BLOCK_CNT_EN
    chk("rst_cnt",   32'(block_cnt), 0);
`endif
    #2 reset_n = 1'b1;

    // next while idle must be ignored
    block_i = blk_abc; next = 1'b1;
    tick();
    next = 1'b0;
    chk("idle_next_busy",  32'(busy), 0);
    chk("idle_next_ready", 32'(ready), 0);
    tick();
    chk("idle_next_busy2", 32'(busy), 0);

    // "abc" block via start
    block_i = blk_abc; start = 1'b1;
    tick();
    start = 1'b0;
    chk("abc_init", 32'(init), 1);
    chk("abc_busy", 32'(busy), 1);
    tick();
    chk("abc_r0_ready", 32'(ready), 1);
    chk("abc_r0_init",  32'(init), 0);
    chk("abc_r0_W", W_o, 32'h61626380);
    chk("abc_r0_K", K_o, 32'h428a2f98);
    for (int r = 1; r < 64; r++) begin
      if (r == 10) begin start = 1'b1; next = 1'b1; block_i = blk_junk; end
      tick();
      if (r == 10) begin start = 1'b0; next = 1'b0; block_i = blk_abc; end
      if (r == 1)  chk("abc_r1_W", W_o, 32'h0);
      if (r == 1)  chk("abc_r1_K", K_o, 32'h71374491);
      if (r == 11) chk("abc_r11_init", 32'(init), 0);
      if (r == 15) chk("abc_r15_W", W_o, 32'h00000018);
      if (r == 16) chk("abc_r16_W", W_o, 32'h61626380);
      if (r == 17) chk("abc_r17_W", W_o, 32'h000f0000);
      if (r == 63) chk("abc_r63_K", K_o, 32'hc67178f2);
      if (r == 63) chk("abc_r63_ready", 32'(ready), 1);
    end
    tick();
    chk("abc_upd",      32'(digest_update), 1);
    chk("abc_upd_rdy",  32'(ready), 0);
    chk("abc_upd_W",    W_o, 0);
    chk("abc_upd_K",    K_o, 0);
    chk("abc_upd_busy", 32'(busy), 1);
    tick();
    chk("abc_done",      32'(done), 1);
    chk("abc_done_busy", 32'(busy), 0);
    chk("abc_done_upd",  32'(digest_update), 0);
    tick();
    chk("abc_done_hold", 32'(done), 1);

    // start+next together in DONE: start wins, block 1 of two-block message
    block_i = blk_m1; start = 1'b1; next = 1'b1;
    tick();
    start = 1'b0; next = 1'b0;
    chk("m1_init", 32'(init), 1);
    chk("m1_done_drop", 32'(done), 0);
    tick();
    chk("m1_r0_W", W_o, 32'h61626364);
    for (int r = 1; r < 64; r++) begin
      tick();
      if (r == 13) chk("m1_r13_W", W_o, 32'h6e6f7071);
      if (r == 14) chk("m1_r14_W", W_o, 32'h80000000);
    end
    tick();
    chk("m1_upd", 32'(digest_update), 1);
    tick();
    chk("m1_done", 32'(done), 1);

    // next in the first DONE cycle: continuation block, no init
    block_i = blk_m2; next = 1'b1;
    tick();
    next = 1'b0;
    chk("m2_no_init", 32'(init), 0);
    chk("m2_r0_ready", 32'(ready), 1);
    chk("m2_r0_W", W_o, 32'h0);
    chk("m2_r0_K", K_o, 32'h428a2f98);
    chk("m2_done_drop", 32'(done), 0);
    for (int r = 1; r < 64; r++) begin
      tick();
      if (r == 15) chk("m2_r15_W", W_o, 32'h000001c0);
      if (r == 16) chk("m2_r16_W", W_o, 32'h0);
      if (r == 17) chk("m2_r17_W", W_o, 32'h00d80000);
    end
    tick();
    chk("m2_upd", 32'(digest_update), 1);
    tick();
    chk("m2_done", 32'(done), 1);

    // reset in the middle of a block
    block_i = blk_abc; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("mid_ready", 32'(ready), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(ready), 0);
    chk("mid_rst_busy",  32'(busy), 0);
    chk("mid_rst_W",     W_o, 0);
    chk("mid_rst_K",     K_o, 0);
    chk("mid_rst_done",  32'(done), 0);
`ifdef SHA256_BLOCK_CNT_EN
    chk("mid_rst_cnt",   32'(block_cnt), 0);
`endif
    tick();
    #2 reset_n = 1'b1;

    block_i = blk_abc; start = 1'b1;
    tick();
    start = 1'b0;
    chk("post_init", 32'(init), 1);
    tick();
    chk("post_r0_W", W_o, 32'h61626380);
    repeat (63) tick();
    chk("post_r63_K", K_o, 32'hc67178f2);
    tick();
    chk("post_upd", 32'(digest_update), 1);
    tick();
    chk("post_done", 32'(done), 1);

`ifdef SHA256_BLOCK_CNT_EN
    chk("cnt_1", 32'(block_cnt), 1);
    for (int b = 0; b < 2; b++) begin
      block_i = blk_m2; next = 1'b1;
      tick();
      next = 1'b0;
      repeat (64) tick();
      tick();
      chk("cnt_blk_done", 32'(done), 1);
    end
    chk("cnt_3", 32'(block_cnt), 3);
    force dut.block_cnt_q = 16'hffff;
    #1;
    release dut.block_cnt_q;
    block_i = blk_m2; next = 1'b1;
    tick();
    next = 1'b0;
    repeat (64) tick();
    tick();
    chk("cnt_wrap_done", 32'(done), 1);
    chk("cnt_wrap", 32'(block_cnt), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
